// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants, FSM encoding and constant-table helpers
// for the sequenced multiply/divide engine.
package gf_pkg;

  localparam int GF_W     = 8;
  localparam int GF_ORDER = 255;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOGA = 3'd1,
    LOGB = 3'd2,
    SUM  = 3'd3,
    EXP  = 3'd4,
    DONE = 3'd5
  } state_t;

  // alpha^n for generator 0x02, evaluated at elaboration time only
  function automatic logic [7:0] gf_pow(input int n, input logic [8:0] poly);
    logic [8:0] x;
    x = 9'h001;
    for (int i = 0; i < n; i++) begin
      x = {x[7:0], 1'b0};
      if (x[8]) x = x ^ poly;
    end
    return x[7:0];
  endfunction

  // discrete log by exhaustive search; log(0) is undefined and returns 0
  function automatic logic [7:0] gf_log_of(input logic [7:0] v, input logic [8:0] poly);
    logic [7:0] r;
    logic [8:0] x;
    r = '0;
    x = 9'h001;
    for (int i = 0; i < GF_ORDER; i++) begin
      if (x[7:0] == v) r = i[7:0];
      x = {x[7:0], 1'b0};
      if (x[8]) x = x ^ poly;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_exp_lut.sv
// GF(2^8) antilog lookup (combinational), the inverse of GF_log for 1..255.
module gf_exp_lut
  import gf_pkg::*;
#(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic [7:0] e,
  output logic [7:0] val
);

  logic [7:0] tbl [256];

  // entry 255 wraps to alpha^0 and is never addressed by the engine
  for (genvar i = 0; i < 256; i++) begin : g_tbl
    localparam logic [7:0] V = gf_pow(i, POLY);
    assign tbl[i] = V;
  end

  assign val = tbl[e];

endmodule

// File: rtl/gf_log.sv
// GF(2^8) discrete-log lookup (combinational), built from the field polynomial.
module GF_log
  import gf_pkg::*;
#(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic [7:0] val,
  output logic [7:0] lg
);

  logic [7:0] tbl [256];

  for (genvar v = 0; v < 256; v++) begin : g_tbl
    localparam logic [7:0] L = gf_log_of(v[7:0], POLY);
    assign tbl[v] = L;
  end

  assign lg = tbl[val];

endmodule

// File: rtl/gf_muldiv_seq.sv
// Sequenced GF(2^8) multiply/divide through one shared log table and an antilog table.
// Divide support and out_div0 are built only when GF_DIV_EN is defined.
module gf_muldiv_seq
  import gf_pkg::*;
#(
  parameter logic [8:0] POLY = 9'h11D,
  parameter bit         B2B  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic       out_div0
);

  state_t     state, state_nxt;
  logic       accept;
  logic       sel_a;
  logic [7:0] a_r, b_r;
  logic       zero_r;
  logic [7:0] la, lb, e_r, e_nxt;
  logic [7:0] log_in, log_out, exp_out;
  logic [8:0] s_mul, e_mul;
  logic [7:0] res_q;
  logic       div0_q;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOGA;
      LOGA:    state_nxt = LOGB;
      LOGB:    state_nxt = SUM;
      SUM:     state_nxt = EXP;
      EXP:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? LOGA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || (B2B && (state == DONE) && out_ready);
    out_valid = (state == DONE);
    sel_a     = (state == LOGA);
  end

  assign log_in = sel_a ? a_r : b_r;

  GF_log #(.POLY(POLY)) u_log (
    .val (log_in),
    .lg  (log_out)
  );

  gf_exp_lut #(.POLY(POLY)) u_exp (
    .e   (e_r),
    .val (exp_out)
  );

  assign s_mul = {1'b0, la} + {1'b0, lb};
  assign e_mul = (s_mul >= 9'd255) ? (s_mul - 9'd255) : s_mul;

`ifdef GF_DIV_EN
  logic op_r, div0_r;

  // la-lb+255 fits in 8 bits whenever la<lb, so modulo-256 arithmetic is exact
  always_comb begin
    e_nxt = e_mul[7:0];
    if (op_r == OP_DIV) e_nxt = (la >= lb) ? (la - lb) : (la - lb + 8'd255);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_MUL;
      div0_r <= 1'b0;
    end else if (accept) begin
      op_r   <= in_op;
      div0_r <= (in_op == OP_DIV) && (in_b == 8'h00);
    end
  end
`else
  logic unused_op;
  logic div0_r;

  assign unused_op = in_op;
  assign div0_r    = 1'b0;
  assign e_nxt     = e_mul[7:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      zero_r <= 1'b0;
      la     <= '0;
      lb     <= '0;
      e_r    <= '0;
      res_q  <= '0;
      div0_q <= 1'b0;
    end else begin
      if (accept) begin
        a_r    <= in_a;
        b_r    <= in_b;
        zero_r <= (in_a == 8'h00) || (in_b == 8'h00);
      end
      case (state)
        LOGA: la <= log_out;
        LOGB: lb <= log_out;
        SUM:  e_r <= e_nxt;
        EXP: begin
          res_q  <= zero_r ? 8'h00 : exp_out;
          div0_q <= div0_r;
        end
        default: ;
      endcase
    end
  end

  assign out_res  = res_q;
  assign out_div0 = div0_q;

endmodule
